wb_multiport_retire: RTL and testbench
======================================

# wb_multiport_retire

Parametrised writeback/retire stage for a multi-lane pipeline. It accepts up to `LANES` completed instructions per cycle from the MEM latch and selects each result (load data or ALU output). Register writes are buffered in a program-ordered queue and drained to the register file through `WR_PORTS` write ports. It also maintains the retired-instruction counter, the `reg10_val` test-status register, and a pending-write mask that DE uses for hazard stalls.

## Interface
Parameters:
- `DBITS`, 32: data width.
- `REGNOBITS`, 5: register index width; the register file has `2**REGNOBITS` entries.
- `LANES`, 2: instructions accepted per cycle. Lane 0 is the oldest.
- `WR_PORTS`, 1: register-file write ports. Legal range is 1..`LANES`.
- `QDEPTH`, 4: write-queue entries. Must satisfy `QDEPTH >= LANES` and be a power of two.
- `CNT_W`, 64: retired-counter width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in `LANES`: per-lane valid. Valid lanes need not be contiguous.
- `in_ready` out 1: all lanes are accepted in a cycle with `in_valid != 0 && in_ready`.
- `in_wr_reg` in `LANES`: lane writes a GPR.
- `in_is_load` in `LANES`: lane result comes from `in_rd_val`.
- `in_wregno` in `LANES*REGNOBITS`: destination register, packed with lane 0 at the LSBs.
- `in_aluout` in `LANES*DBITS`: ALU result.
- `in_rd_val` in `LANES*DBITS`: load data.
- `out_we` out `WR_PORTS`: register-file write enable.
- `out_wregno` out `WR_PORTS*REGNOBITS`: write index.
- `out_wdata` out `WR_PORTS*DBITS`: write data.
- `pending_mask` out `2**REGNOBITS`: bit r = a write to r is queued or on the out ports.
- `instret` out `CNT_W`: retired-instruction count.
- `reg10_val` out `DBITS`: last value written to x10.

## Operation
- Per lane: `regval = in_is_load ? rd_val : aluout`.
- Accepted lane with `wr_reg=1` and `wregno!=0`:
  - pushed to the queue in lane order (lane 0 first);
  - k such lanes push k entries in one cycle.
- Accepted lane with `wr_reg=0` or `wregno=0` retires without a queue entry. Writes to x0 are discarded.
- Drain: each cycle, min(count, `WR_PORTS`) oldest entries are popped into registered out ports.
  - The oldest entry goes to port 0.
  - Unused ports have `out_we=0`, and their wregno/wdata are 0.
- Same register on two ports in one cycle: the higher port index is younger, and the register file must apply it last.
- `in_ready = (QDEPTH - count) >= LANES`, using the registered count. Same-cycle pops are not credited, so the rule is conservative.
- `instret` increments by popcount(`in_valid`) per accepting cycle, including non-writing lanes. It wraps modulo 2^`CNT_W`.
- `reg10_val` loads `out_wdata[p]` when `out_we[p]` and `out_wregno[p]==10`. If several ports qualify, the highest p wins.
- `pending_mask` is the combinational OR over valid queue entries plus currently asserted out ports.

## Timing
- Reset values: `out_we`, `out_wregno`, `out_wdata`, `instret`, `reg10_val` and `pending_mask` are all 0. The queue is emptied.
- `in_ready` is 0 while `reset` is high and 1 on the first cycle after release.
- Latency:
  - An entry accepted at cycle t is on the out ports no earlier than t+1.
  - With an empty queue and entries ≤ `WR_PORTS`, it is on the out ports exactly at t+1.
- `instret` reflects acceptance at t on cycle t+1.
- `pending_mask` sets at t+1 for an accept at t, and clears the cycle after the write leaves the out ports.
- Push and pop in the same cycle are both performed. `count_next = count + pushes - pops`.
- Pointers wrap modulo `QDEPTH`.
- Full: `in_ready=0`. `in_valid` asserted while not ready is ignored, with no push and no count.
- Empty: all `out_we=0`.
- Reset mid-drain: queued writes are lost, which is acceptable because the pipeline is flushed by the same reset.

## Structure
- Package `wb_pkg`:
  - width localparams;
  - `wb_entry_t` {wregno, wdata};
  - `wb_regval` select function;
  - lane-slice helper functions.
- Sub-module `wb_wr_queue`:
  - multi-push (≤`LANES`), multi-pop (≤`WR_PORTS`) circular FIFO;
  - outputs count and an entry-valid vector for `pending_mask`.
- The top level handles lane filtering and compaction, the output registers, `instret`, `reg10_val` and the mask.

## Test plan
1. **Reset, then a single write.** Reset, then lane 0 valid with wr_reg=1, wregno=5, aluout=0x1234.
   - Cycle t+1: `out_we[0]=1`, `out_wregno=5`, `out_wdata=0x1234`, `pending_mask[5]=1`.
   - `instret=1`.
2. **Load select and x0.** LANES=2: lane 0 is a load to x3 (rd_val=0xAA, aluout=0xBB); lane 1 writes x0.
   - Only x3 is written, with data 0xAA.
   - `instret` increments by 2.
3. **Backpressure.** WR_PORTS=1, QDEPTH=4, two writing lanes every cycle.
   - `in_ready` drops once count>2.
   - Writes emerge one per cycle in program order (lane 0 before lane 1, then the next cycle's lanes).
   - No entries are lost or duplicated.
4. **reg10 conflict.** WR_PORTS=2, both lanes write x10 (0x11 then 0x22).
   - Both ports fire in the same cycle.
   - `reg10_val=0x22` on the next cycle.
5. **Reset mid-operation.** Assert reset with 3 entries queued.
   - Next cycle: all outputs 0 and `pending_mask=0`.
   - After release, `in_ready=1`.
6. **Counter wrap.** CNT_W=4, retire 17 instructions.
   - `instret=1`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, queue entry layout and lane helpers for the writeback/retire stage.
package wb_pkg;

  localparam int WB_DBITS     = 32;
  localparam int WB_REGNOBITS = 5;
  localparam int WB_MAX_DBITS = 64;

  typedef struct packed {
    logic [WB_REGNOBITS-1:0] wregno;
    logic [WB_DBITS-1:0]     wdata;
  } wb_entry_t;

  function automatic logic [WB_MAX_DBITS-1:0] wb_regval(
    input logic                    is_load,
    input logic [WB_MAX_DBITS-1:0] aluout,
    input logic [WB_MAX_DBITS-1:0] rd_val
  );
    logic [WB_MAX_DBITS-1:0] val;
    if (is_load) begin
      val = rd_val;
    end else begin
      val = aluout;
    end
    return val;
  endfunction

  // Bit offset of a lane's field inside a lane-packed bus (lane 0 at the LSBs).
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/wb_wr_queue.sv
// Program-ordered circular write queue: up to LANES pushes and WR_PORTS pops per cycle.
// Pops take stored entries first and may take same-cycle pushes directly.
module wb_wr_queue
  import wb_pkg::*;
#(
  parameter int EW       = 37,
  parameter int TAG_W    = 5,
  parameter int LANES    = 2,
  parameter int WR_PORTS = 1,
  parameter int QDEPTH   = 4,
  parameter int CQ       = $clog2(QDEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CQ-1:0]            push_cnt,
  input  logic [LANES*EW-1:0]      push_data,
  output logic [CQ-1:0]            count,
  output logic [CQ-1:0]            pop_cnt,
  output logic [WR_PORTS*EW-1:0]   pop_data,
  output logic [QDEPTH-1:0]        entry_valid,
  output logic [QDEPTH*TAG_W-1:0]  entry_tag
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [EW-1:0]    mem_r [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CQ-1:0]    count_r;
  logic [CQ-1:0]    avail_s;
  logic [CQ-1:0]    pop_cnt_s;

  // Pop selection: stored entries first, then this cycle's pushes in order.
  always_comb begin
    avail_s = count_r + push_cnt;
    if (avail_s > CQ'(WR_PORTS)) begin
      pop_cnt_s = CQ'(WR_PORTS);
    end else begin
      pop_cnt_s = avail_s;
    end
    pop_data = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (CQ'(p) < count_r) begin
        pop_data[p*EW +: EW] = mem_r[rd_ptr_r + PTR_W'(p)];
      end else if (CQ'(p) < avail_s) begin
        pop_data[p*EW +: EW] = push_data[lane_lsb(p - int'(count_r), EW) +: EW];
      end else begin
        pop_data[p*EW +: EW] = '0;
      end
    end
  end

  // Storage and pointers; bypassed pushes are written then skipped by rd_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (CQ'(i) < push_cnt) begin
          mem_r[wr_ptr_r + PTR_W'(i)] <= push_data[lane_lsb(i, EW) +: EW];
        end
      end
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt_s);
      count_r  <= avail_s - pop_cnt_s;
    end
  end

  // Live-entry view used for the pending-write mask.
  always_comb begin
    logic [PTR_W-1:0] off_v;
    off_v = '0;
    for (int q = 0; q < QDEPTH; q++) begin
      off_v                     = PTR_W'(q) - rd_ptr_r;
      entry_valid[q]            = (CQ'(off_v) < count_r);
      entry_tag[q*TAG_W +: TAG_W] = mem_r[q][EW-1 -: TAG_W];
    end
  end

  assign count   = count_r;
  assign pop_cnt = pop_cnt_s;

endmodule

// File: rtl/wb_multiport_retire.sv
// Multi-lane writeback/retire: lane filtering and compaction into the write queue,
// registered register-file write ports, retired counter, x10 mirror and hazard mask.
module wb_multiport_retire
  import wb_pkg::*;
#(
  parameter int DBITS     = WB_DBITS,
  parameter int REGNOBITS = WB_REGNOBITS,
  parameter int LANES     = 2,
  parameter int WR_PORTS  = 1,
  parameter int QDEPTH    = 4,
  parameter int CNT_W     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_wr_reg,
  input  logic [LANES-1:0]              in_is_load,
  input  logic [LANES*REGNOBITS-1:0]    in_wregno,
  input  logic [LANES*DBITS-1:0]        in_aluout,
  input  logic [LANES*DBITS-1:0]        in_rd_val,
  output logic [WR_PORTS-1:0]           out_we,
  output logic [WR_PORTS*REGNOBITS-1:0] out_wregno,
  output logic [WR_PORTS*DBITS-1:0]     out_wdata,
  output logic [2**REGNOBITS-1:0]       pending_mask,
  output logic [CNT_W-1:0]              instret,
  output logic [DBITS-1:0]              reg10_val
);

  localparam int EW   = REGNOBITS + DBITS;
  localparam int CQ   = $clog2(QDEPTH + 1);
  localparam int PC_W = $clog2(LANES + 1);

  logic                          accept_s;
  logic [CQ-1:0]                 push_cnt_s;
  logic [CQ-1:0]                 count_s;
  logic [CQ-1:0]                 pop_cnt_s;
  logic [LANES*EW-1:0]           push_data_s;
  logic [WR_PORTS*EW-1:0]        pop_data_s;
  logic [QDEPTH-1:0]             entry_valid_s;
  logic [QDEPTH*REGNOBITS-1:0]   entry_tag_s;
  logic [PC_W-1:0]               retire_cnt_s;
  logic [2**REGNOBITS-1:0]       mask_s;
  logic [WR_PORTS-1:0]           out_we_r;
  logic [WR_PORTS*REGNOBITS-1:0] out_wregno_r;
  logic [WR_PORTS*DBITS-1:0]     out_wdata_r;
  logic [CNT_W-1:0]              instret_r;
  logic [DBITS-1:0]              reg10_r;

  // Conservative credit: same-cycle pops are not counted as free space.
  assign in_ready = ~reset & ((CQ'(QDEPTH) - count_s) >= CQ'(LANES));
  assign accept_s = (|in_valid) & in_ready;

  // Compact writing lanes in lane order; a non-writing lane leaves its slot to the next writer.
  always_comb begin
    logic [DBITS-1:0]     val_v;
    logic [REGNOBITS-1:0] rno_v;
    logic                 wr_v;
    int                   n_v;
    n_v          = 0;
    push_data_s  = '0;
    retire_cnt_s = '0;
    for (int i = 0; i < LANES; i++) begin
      rno_v = in_wregno[lane_lsb(i, REGNOBITS) +: REGNOBITS];
      val_v = DBITS'(wb_regval(in_is_load[i],
                               WB_MAX_DBITS'(in_aluout[lane_lsb(i, DBITS) +: DBITS]),
                               WB_MAX_DBITS'(in_rd_val[lane_lsb(i, DBITS) +: DBITS])));
      wr_v  = accept_s & in_valid[i] & in_wr_reg[i] & (rno_v != '0);
      push_data_s[lane_lsb(n_v, EW) +: EW] = {rno_v, val_v};
      n_v          = n_v + int'(wr_v);
      retire_cnt_s = retire_cnt_s + PC_W'(accept_s & in_valid[i]);
    end
    push_cnt_s = CQ'(n_v);
  end

  wb_wr_queue #(
    .EW       (EW),
    .TAG_W    (REGNOBITS),
    .LANES    (LANES),
    .WR_PORTS (WR_PORTS),
    .QDEPTH   (QDEPTH),
    .CQ       (CQ)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_cnt    (push_cnt_s),
    .push_data   (push_data_s),
    .count       (count_s),
    .pop_cnt     (pop_cnt_s),
    .pop_data    (pop_data_s),
    .entry_valid (entry_valid_s),
    .entry_tag   (entry_tag_s)
  );

  // Register popped entries onto the write ports; oldest goes to port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_we_r     <= '0;
      out_wregno_r <= '0;
      out_wdata_r  <= '0;
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (CQ'(p) < pop_cnt_s) begin
          out_we_r[p]                                <= 1'b1;
          out_wregno_r[p*REGNOBITS +: REGNOBITS]     <= pop_data_s[p*EW + DBITS +: REGNOBITS];
          out_wdata_r[p*DBITS +: DBITS]              <= pop_data_s[p*EW +: DBITS];
        end else begin
          out_we_r[p]                                <= 1'b0;
          out_wregno_r[p*REGNOBITS +: REGNOBITS]     <= '0;
          out_wdata_r[p*DBITS +: DBITS]              <= '0;
        end
      end
    end
  end

  // Retired-instruction counter, wrapping at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= '0;
    end else begin
      instret_r <= instret_r + CNT_W'(retire_cnt_s);
    end
  end

  // x10 mirror; iterating upward lets the youngest port win.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg10_r <= '0;
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (out_we_r[p] && (out_wregno_r[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(10))) begin
          reg10_r <= out_wdata_r[p*DBITS +: DBITS];
        end
      end
    end
  end

  // Pending-write mask: queued entries plus writes currently on the ports.
  always_comb begin
    mask_s = '0;
    for (int q = 0; q < QDEPTH; q++) begin
      mask_s[entry_tag_s[q*REGNOBITS +: REGNOBITS]] =
        mask_s[entry_tag_s[q*REGNOBITS +: REGNOBITS]] | entry_valid_s[q];
    end
    for (int p = 0; p < WR_PORTS; p++) begin
      mask_s[out_wregno_r[p*REGNOBITS +: REGNOBITS]] =
        mask_s[out_wregno_r[p*REGNOBITS +: REGNOBITS]] | out_we_r[p];
    end
  end

  assign out_we       = out_we_r;
  assign out_wregno   = out_wregno_r;
  assign out_wdata    = out_wdata_r;
  assign instret      = instret_r;
  assign reg10_val    = reg10_r;
  assign pending_mask = mask_s;

endmodule

// File: tb/tb_wb_multiport_retire.sv
// Directed bench: instance a (1 write port, 64-bit counter) and instance b
// (2 write ports, 4-bit counter) share stimulus; each test checks one of them.
module tb_wb_multiport_retire;
  import wb_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  in_valid;
  logic [1:0]  in_wr_reg;
  logic [1:0]  in_is_load;
  logic [9:0]  in_wregno;
  logic [63:0] in_aluout;
  logic [63:0] in_rd_val;

  logic        a_ready;
  logic [0:0]  a_out_we;
  logic [4:0]  a_out_wregno;
  logic [31:0] a_out_wdata;
  logic [31:0] a_mask;
  logic [63:0] a_instret;
  logic [31:0] a_reg10;

  logic        b_ready;
  logic [1:0]  b_out_we;
  logic [9:0]  b_out_wregno;
  logic [63:0] b_out_wdata;
  logic [31:0] b_mask;
  logic [3:0]  b_instret;
  logic [31:0] b_reg10;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  wb_multiport_retire #(.LANES(2), .WR_PORTS(1), .QDEPTH(4), .CNT_W(64)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ready),
    .in_wr_reg(in_wr_reg), .in_is_load(in_is_load), .in_wregno(in_wregno),
    .in_aluout(in_aluout), .in_rd_val(in_rd_val), .out_we(a_out_we),
    .out_wregno(a_out_wregno), .out_wdata(a_out_wdata), .pending_mask(a_mask),
    .instret(a_instret), .reg10_val(a_reg10)
  );

  wb_multiport_retire #(.LANES(2), .WR_PORTS(2), .QDEPTH(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ready),
    .in_wr_reg(in_wr_reg), .in_is_load(in_is_load), .in_wregno(in_wregno),
    .in_aluout(in_aluout), .in_rd_val(in_rd_val), .out_we(b_out_we),
    .out_wregno(b_out_wregno), .out_wdata(b_out_wdata), .pending_mask(b_mask),
    .instret(b_instret), .reg10_val(b_reg10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid   = 2'b00;
    in_wr_reg  = 2'b00;
    in_is_load = 2'b00;
    in_wregno  = 10'd0;
    in_aluout  = 64'd0;
    in_rd_val  = 64'd0;
  endtask

  task automatic set_lane(input int l, input logic wr, input logic ld, input logic [4:0] rno,
                          input logic [31:0] alu, input logic [31:0] rd);
    in_valid[l]            = 1'b1;
    in_wr_reg[l]           = wr;
    in_is_load[l]          = ld;
    in_wregno[l*5 +: 5]    = rno;
    in_aluout[l*32 +: 32]  = alu;
    in_rd_val[l*32 +: 32]  = rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [4:0] bp_reg(input int s);
    return 5'(s % 31 + 1);
  endfunction

  function automatic logic [31:0] bp_dat(input int s);
    return 32'h100 + 32'(s);
  endfunction

  initial begin
    int        mcount;
    int        sent;
    int        rcv;
    int        pops;
    logic      exp_ready;
    wb_entry_t exp_e;

    reset = 1'b1;
    clear_in();

    // 1: reset state, then a single ALU write to x5
    tick();
    tick();
    check_vec("rst_we",      64'(a_out_we),     64'h0);
    check_vec("rst_wregno",  64'(a_out_wregno), 64'h0);
    check_vec("rst_wdata",   64'(a_out_wdata),  64'h0);
    check_vec("rst_instret", a_instret,         64'h0);
    check_vec("rst_reg10",   64'(a_reg10),      64'h0);
    check_vec("rst_mask",    64'(a_mask),       64'h0);
    check_vec("rst_ready",   64'(a_ready),      64'h0);
    reset = 1'b0;
    #1;
    check_vec("rel_ready", 64'(a_ready), 64'h1);
    set_lane(0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    tick();
    clear_in();
    check_vec("w1_we",      64'(a_out_we),     64'h1);
    check_vec("w1_wregno",  64'(a_out_wregno), 64'h5);
    check_vec("w1_wdata",   64'(a_out_wdata),  64'h1234);
    check_vec("w1_mask",    64'(a_mask),       64'h20);
    check_vec("w1_instret", a_instret,         64'h1);
    tick();
    check_vec("w1_we_clr",   64'(a_out_we), 64'h0);
    check_vec("w1_mask_clr", 64'(a_mask),   64'h0);

    // 2: load select on lane 0, x0 write on lane 1 discarded
    do_reset();
    set_lane(0, 1'b1, 1'b1, 5'd3, 32'hBB, 32'hAA);
    set_lane(1, 1'b1, 1'b0, 5'd0, 32'h77, 32'h0);
    tick();
    clear_in();
    check_vec("ld_we",      64'(a_out_we),     64'h1);
    check_vec("ld_wregno",  64'(a_out_wregno), 64'h3);
    check_vec("ld_wdata",   64'(a_out_wdata),  64'hAA);
    check_vec("ld_instret", a_instret,         64'h2);
    tick();
    check_vec("x0_no_write", 64'(a_out_we), 64'h0);

    // 3: backpressure with two writers per cycle into one port
    do_reset();
    mcount = 0;
    sent   = 0;
    rcv    = 0;
    for (int cyc = 0; cyc < 60 && rcv < 12; cyc++) begin
      clear_in();
      exp_ready = ((4 - mcount) >= 2);
      if (sent < 12) begin
        set_lane(0, 1'b1, 1'b0, bp_reg(sent),     bp_dat(sent),     32'h0);
        set_lane(1, 1'b1, 1'b0, bp_reg(sent + 1), bp_dat(sent + 1), 32'h0);
      end
      #1;
      check_vec("bp_ready", 64'(a_ready), 64'(exp_ready));
      if (sent < 12 && exp_ready) begin
        sent   += 2;
        mcount += 2;
      end
      pops   = (mcount > 0) ? 1 : 0;
      mcount -= pops;
      tick();
      check_vec("bp_we", 64'(a_out_we), 64'(pops));
      if (a_out_we[0]) begin
        exp_e.wregno = bp_reg(rcv);
        exp_e.wdata  = bp_dat(rcv);
        check_vec("bp_entry", 64'({a_out_wregno, a_out_wdata}), 64'(exp_e));
        rcv++;
      end
    end
    clear_in();
    check_vec("bp_total",   64'(rcv),  64'd12);
    check_vec("bp_instret", a_instret, 64'd12);
    tick();
    check_vec("bp_no_dup", 64'(a_out_we), 64'h0);

    // 4: both lanes write x10 through two ports; youngest wins
    do_reset();
    set_lane(0, 1'b1, 1'b0, 5'd10, 32'h11, 32'h0);
    set_lane(1, 1'b1, 1'b0, 5'd10, 32'h22, 32'h0);
    tick();
    clear_in();
    check_vec("r10_we",     64'(b_out_we),     64'h3);
    check_vec("r10_wregno", 64'(b_out_wregno), 64'h14A);
    check_vec("r10_wdata",  b_out_wdata,       64'h00000022_00000011);
    check_vec("r10_mask",   64'(b_mask),       64'h400);
    check_vec("r10_early",  64'(b_reg10),      64'h0);
    tick();
    check_vec("r10_val",    64'(b_reg10),      64'h22);
    check_vec("r10_we_clr", 64'(b_out_we),     64'h0);

    // 5: reset with three entries queued
    do_reset();
    set_lane(0, 1'b1, 1'b0, 5'd10, 32'h55, 32'h0);
    set_lane(1, 1'b1, 1'b0, 5'd11, 32'h66, 32'h0);
    tick();
    set_lane(0, 1'b1, 1'b0, 5'd12, 32'h67, 32'h0);
    set_lane(1, 1'b1, 1'b0, 5'd13, 32'h68, 32'h0);
    tick();
    set_lane(0, 1'b1, 1'b0, 5'd14, 32'h69, 32'h0);
    set_lane(1, 1'b1, 1'b0, 5'd15, 32'h6A, 32'h0);
    tick();
    clear_in();
    check_vec("mid_ready",  64'(a_ready),      64'h0);
    check_vec("mid_mask",   64'(a_mask),       64'h0000F000);
    check_vec("mid_wregno", 64'(a_out_wregno), 64'd12);
    check_vec("mid_reg10",  64'(a_reg10),      64'h55);
    reset = 1'b1;
    tick();
    check_vec("mr_we",      64'(a_out_we),     64'h0);
    check_vec("mr_wregno",  64'(a_out_wregno), 64'h0);
    check_vec("mr_wdata",   64'(a_out_wdata),  64'h0);
    check_vec("mr_mask",    64'(a_mask),       64'h0);
    check_vec("mr_instret", a_instret,         64'h0);
    check_vec("mr_reg10",   64'(a_reg10),      64'h0);
    check_vec("mr_ready",   64'(a_ready),      64'h0);
    reset = 1'b0;
    #1;
    check_vec("mr_rel_ready", 64'(a_ready), 64'h1);
    tick();
    check_vec("mr_drained", 64'(a_out_we), 64'h0);

    // 6: 4-bit counter wraps after 17 retirements
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clear_in();
      set_lane(0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      set_lane(1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
    end
    clear_in();
    check_vec("wrap_16", 64'(b_instret), 64'h0);
    set_lane(1, 1'b0, 1'b0, 5'd7, 32'h0, 32'h0);
    tick();
    clear_in();
    check_vec("wrap_17", 64'(b_instret), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
